// File: rtl/mic_delay_sum.sv
// rtl/mic_delay_sum.sv - two-mic delay-and-sum stage feeding the codec write port
module mic_delay_sum #(
   parameter int DW        = 16,
   parameter int MAX_DELAY = 32,
   parameter int AW        = 5
) (
   input  logic          CLOCK_50,
   input  logic          reset_n,
   input  logic          adc_lrck,
   input  logic [DW-1:0] mic_L,
   input  logic [DW-1:0] mic_R,
   input  logic [AW-1:0] delay_sel,
   input  logic          steer_right,
   input  logic          write_ready,
   output logic          write,
   output logic [DW-1:0] writedata_left,
   output logic [DW-1:0] writedata_right,
   output logic          overrun
);

   typedef enum logic [1:0] {IDLE, RD, SUM, OUT} state_t;

   localparam logic [AW:0] FILL_MAX = (AW+1)'(MAX_DELAY);

   state_t        state, state_nxt;
   logic          s1, s2, s3;
   logic          frame;
   logic [DW-1:0] cap_l, cap_r, rd_data;
   logic [AW-1:0] d, wp, rd_addr;
   logic          st;
   logic [AW:0]   fill;
   logic          hit;
   logic [DW-1:0] mem [MAX_DELAY];
   logic [DW-1:0] steered, undelayed, dly;
   logic [DW:0]   sum;

   assign frame     = s2 & ~s3;
   assign rd_addr   = wp - d;
   assign steered   = st ? cap_l : cap_r;
   assign undelayed = st ? cap_r : cap_l;
   // d==0 bypasses the buffer; otherwise samples older than the fill level read as silence
   assign dly       = (d == '0) ? steered : (hit ? rd_data : '0);
   assign sum       = {undelayed[DW-1], undelayed} + {dly[DW-1], dly};

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame) state_nxt = RD;
         RD:      state_nxt = SUM;
         SUM:     state_nxt = OUT;
         OUT:     if (write_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      write = (state == OUT) && write_ready;
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         s1              <= 1'b0;
         s2              <= 1'b0;
         s3              <= 1'b0;
         cap_l           <= '0;
         cap_r           <= '0;
         d               <= '0;
         st              <= 1'b0;
         wp              <= '0;
         fill            <= '0;
         hit             <= 1'b0;
         rd_data         <= '0;
         writedata_left  <= '0;
         writedata_right <= '0;
         overrun         <= 1'b0;
      end else begin
         s1 <= adc_lrck;
         s2 <= s1;
         s3 <= s2;
         if (frame && state == IDLE) begin
            cap_l <= mic_L;
            cap_r <= mic_R;
            d     <= delay_sel;
            st    <= steer_right;
         end
         if (frame && state != IDLE) overrun <= 1'b1;
         if (state == RD) begin
            rd_data <= mem[rd_addr];
            hit     <= (fill >= {1'b0, d});
            wp      <= wp + 1'b1;
            if (fill != FILL_MAX) fill <= fill + 1'b1;
         end
         if (state == SUM) begin
            writedata_left  <= sum[DW:1];
            writedata_right <= sum[DW:1];
         end
      end
   end

   // buffer RAM is deliberately not reset; fill gating masks stale entries
   always_ff @(posedge CLOCK_50) begin
      if (state == RD) mem[wp] <= steered;
   end

endmodule
